// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Hard-wired control unit. Walks fetch (T0..T2) and execute
//             (T3..T6) states and decodes per-state strobes from the state
//             register and the instruction register.
//  Revision : 1.0  initial release
// ============================================================================
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Read,
    output logic        Yin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  ALUopcode,
    output logic        Run,
    output logic        Illegal
);

    localparam logic [3:0] c_ST_RESET = 4'd0;
    localparam logic [3:0] c_ST_T0    = 4'd1;
    localparam logic [3:0] c_ST_T1    = 4'd2;
    localparam logic [3:0] c_ST_T2    = 4'd3;
    localparam logic [3:0] c_ST_T3    = 4'd4;
    localparam logic [3:0] c_ST_T4    = 4'd5;
    localparam logic [3:0] c_ST_T5    = 4'd6;
    localparam logic [3:0] c_ST_T6    = 4'd7;
    localparam logic [3:0] c_ST_HALT  = 4'd8;

    localparam logic [4:0] c_OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] c_OP_ALU_LAST  = 5'b01011;
    localparam logic [4:0] c_OP_MUL       = 5'b01111;
    localparam logic [4:0] c_OP_DIV       = 5'b10000;
    localparam logic [4:0] c_OP_HALT      = 5'b11011;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       r_illegal;

    logic [4:0] w_op;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_is_alu;
    logic       w_is_muldiv;
    logic       w_is_halt;
    logic       w_set_illegal;
    logic       w_unused_ir;

    assign w_op = IR[31:27];
    assign w_ra = IR[26:23];
    assign w_rb = IR[22:19];
    assign w_rc = IR[18:15];
    // Low immediate bits carry no control information.
    assign w_unused_ir = ^IR[14:0];

    assign w_is_alu      = (w_op >= c_OP_ALU_FIRST) && (w_op <= c_OP_ALU_LAST);
    assign w_is_muldiv   = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
    assign w_is_halt     = (w_op == c_OP_HALT);
    // Opcode is only trusted from T3; unknown opcodes trap there.
    assign w_set_illegal = (r_state == c_ST_T3) && !w_is_alu && !w_is_muldiv && !w_is_halt;

    assign Illegal = r_illegal;

    // State register and sticky illegal flag; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_ST_RESET;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state: linear fetch, opcode branch at T3, Stop sampled at the last execute state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RESET: w_next_state = c_ST_T0;
            c_ST_T0:    w_next_state = c_ST_T1;
            c_ST_T1:    w_next_state = c_ST_T2;
            c_ST_T2:    w_next_state = c_ST_T3;
            c_ST_T3:    w_next_state = (w_is_alu || w_is_muldiv) ? c_ST_T4 : c_ST_HALT;
            c_ST_T4:    w_next_state = c_ST_T5;
            c_ST_T5: begin
                if (w_is_muldiv) begin
                    w_next_state = c_ST_T6;
                end else begin
                    w_next_state = Stop ? c_ST_HALT : c_ST_T0;
                end
            end
            c_ST_T6:    w_next_state = Stop ? c_ST_HALT : c_ST_T0;
            c_ST_HALT:  w_next_state = c_ST_HALT;
            default:    w_next_state = c_ST_RESET;
        endcase
    end

    // Moore output decode from state and (from T3 on) instruction fields.
    always_comb begin
        Rin       = 16'h0000;
        Rout      = 16'h0000;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Read      = 1'b0;
        Yin       = 1'b0;
        Zhighin   = 1'b0;
        Zlowin    = 1'b0;
        Zhighout  = 1'b0;
        Zlowout   = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ALUopcode = 5'b00000;
        Run       = 1'b0;
        case (r_state)
            c_ST_T0: begin
                Run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zhighin = 1'b1;
                Zlowin  = 1'b1;
            end
            c_ST_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            c_ST_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            c_ST_T3: begin
                Run = 1'b1;
                if (w_is_alu) begin
                    Rout = 16'h0001 << w_rb;
                    Yin  = 1'b1;
                end else if (w_is_muldiv) begin
                    Rout = 16'h0001 << w_ra;
                    Yin  = 1'b1;
                end
            end
            c_ST_T4: begin
                Run = 1'b1;
                if (w_is_alu || w_is_muldiv) begin
                    Rout      = 16'h0001 << (w_is_alu ? w_rc : w_rb);
                    ALUopcode = w_op;
                    Zhighin   = 1'b1;
                    Zlowin    = 1'b1;
                end
            end
            c_ST_T5: begin
                Run = 1'b1;
                if (w_is_alu) begin
                    Zlowout = 1'b1;
                    Rin     = 16'h0001 << w_ra;
                end else if (w_is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            c_ST_T6: begin
                Run = 1'b1;
                if (w_is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Directed stimulus for control_sequencer with an instruction-
//             level reference model checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        Stop;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read;
    logic        Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin;
    logic [4:0]  ALUopcode;
    logic        Run, Illegal;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Read(Read),
        .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
        .ALUopcode(ALUopcode), .Run(Run), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, read;
        logic yin, zhin, zlin, zhout, zlout, hiin, loin;
        logic [4:0] aluop;
        logic run, illegal;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
                    Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin,
                    ALUopcode, Run, Illegal};

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [31:0] I_SHRA = 32'h409A8000;
    localparam logic [31:0] I_MUL  = {5'b01111, 4'd2, 4'd4, 4'd0, 15'd0};
    localparam logic [31:0] I_ADD  = {5'b00011, 4'd7, 4'd1, 4'd2, 15'd0};
    localparam logic [31:0] I_SUB  = {5'b00100, 4'd3, 4'd5, 4'd6, 15'd0};
    localparam logic [31:0] I_ILL  = {5'b11111, 27'd0};
    localparam logic [31:0] I_HLT  = {5'b11011, 27'd0};

    // ---------------- reference model ----------------
    // Phase: -1 = reset, 0..6 = step within instruction, 7 = halted.
    int   m_st    = -1;
    bit   m_ill   = 1'b0;
    bit   m_valid = 1'b0;
    outs_t m_exp;

    function automatic bit is_alu(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd11);
    endfunction

    function automatic bit is_md(input logic [4:0] op);
        return (op == 5'd15) || (op == 5'd16);
    endfunction

    // Index of the final execute step for a supported instruction.
    function automatic int last_step(input logic [4:0] op);
        return is_md(op) ? 6 : 5;
    endfunction

    function automatic outs_t model_out(input int st, input logic [31:0] ir, input bit ill);
        outs_t o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit alu, md;
        o = '0;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        alu = is_alu(op); md = is_md(op);
        o.illegal = ill;
        o.run = (st >= 0) && (st <= 6);
        case (st)
            0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zhin = 1; o.zlin = 1; end
            1: begin o.zlout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; end
            2: begin o.mdrout = 1; o.irin = 1; end
            3: if (alu || md) begin o.rout = 16'h0001 << (alu ? rb : ra); o.yin = 1; end
            4: if (alu || md) begin
                   o.rout = 16'h0001 << (alu ? rc : rb);
                   o.aluop = op; o.zhin = 1; o.zlin = 1;
               end
            5: if (alu) begin o.zlout = 1; o.rin = 16'h0001 << ra; end
               else if (md) begin o.zlout = 1; o.loin = 1; end
            6: if (md) begin o.zhout = 1; o.hiin = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // Advance the model on each rising edge using the same inputs the DUT sees.
    always @(posedge clk) begin
        if (clr) begin
            m_st = -1; m_ill = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_st == 7) begin
                m_st = 7;
            end else if (m_st == 3) begin
                if (is_alu(IR[31:27]) || is_md(IR[31:27])) m_st = 4;
                else begin
                    if (IR[31:27] != 5'b11011) m_ill = 1'b1;
                    m_st = 7;
                end
            end else if (m_st >= 4 && m_st == last_step(IR[31:27])) begin
                m_st = Stop ? 7 : 0;
            end else begin
                m_st = m_st + 1;
            end
        end
    end

    // Full-output comparison mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            m_exp = model_out(m_st, IR, m_ill);
            vectors++;
            if (dut_o !== m_exp) begin
                miscompares++;
                $display("FAIL cycle_compare phase=%0d t=%0t: got %h expected %h", m_st, $time, dut_o, m_exp);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs for the next rising edge, then return mid-cycle after it.
    task automatic drive(input logic c, input logic [31:0] ir, input logic s);
        #1;
        clr = c; IR = ir; Stop = s;
        @(negedge clk);
    endtask

    task automatic fetch_to_t3(input logic [31:0] ir);
        drive(1'b0, 32'hFFFF_FFFF, 1'b0);   // T1, garbage IR during fetch
        drive(1'b0, ir, 1'b0);              // T2
        drive(1'b0, ir, 1'b0);              // T3
    endtask

    outs_t pin;
    logic [4:0] ops [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd11, 5'd16};

    initial begin
        clr = 1'b1; IR = 32'h0; Stop = 1'b0;
        @(negedge clk);

        // Pin the model to hand-computed values.
        pin = model_out(3, I_SHRA, 1'b0); chk("model_shra_T3_rout", pin.rout, 32'h0008);
        pin = model_out(4, I_SHRA, 1'b0); chk("model_shra_T4_rout", pin.rout, 32'h0020);
        pin = model_out(5, I_SHRA, 1'b0); chk("model_shra_T5_rin",  pin.rin,  32'h0002);
        pin = model_out(6, I_MUL,  1'b0); chk("model_mul_T6_hiin",  pin.hiin, 32'h1);

        // Reset state
        chk("reset_run", Run, 0);
        chk("reset_illegal", Illegal, 0);
        chk("reset_regs", {Rin, Rout}, 0);

        // Fetch with garbage IR, then shift instruction
        drive(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("T0_strobes", {PCout, MARin, IncPC, Zhighin, Zlowin, Run}, 6'b111111);
        chk("T0_regs", {Rin, Rout}, 0);
        drive(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("T1_strobes", {Zlowout, PCin, Read, MDRin, Run}, 5'b11111);
        drive(1'b0, I_SHRA, 1'b0);
        chk("T2_strobes", {MDRout, IRin, Run}, 3'b111);
        drive(1'b0, I_SHRA, 1'b0);
        chk("shra_T3_rout", Rout, 32'h0008);
        chk("shra_T3_yin", Yin, 1);
        drive(1'b0, I_SHRA, 1'b0);
        chk("shra_T4_rout", Rout, 32'h0020);
        chk("shra_T4_aluop", ALUopcode, 5'b01000);
        chk("shra_T4_z", {Zhighin, Zlowin}, 2'b11);
        drive(1'b0, I_SHRA, 1'b0);
        chk("shra_T5_zlowout", Zlowout, 1);
        chk("shra_T5_rin", Rin, 32'h0002);
        drive(1'b0, I_SHRA, 1'b0);
        chk("shra_next_T0", {PCout, Run}, 2'b11);

        // Multiply
        fetch_to_t3(I_MUL);
        chk("mul_T3_rout", Rout, 32'h0004);
        drive(1'b0, I_MUL, 1'b0);
        chk("mul_T4_rout", Rout, 32'h0010);
        chk("mul_T4_aluop", ALUopcode, 5'b01111);
        drive(1'b0, I_MUL, 1'b0);
        chk("mul_T5_loin", LOin, 1);
        drive(1'b0, I_MUL, 1'b0);
        chk("mul_T6_hiin", HIin, 1);
        drive(1'b0, I_MUL, 1'b0);
        chk("mul_next_T0", PCout, 1);

        // Further ALU and divide instructions; cycle compare checks every state
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ir;
            ir = {ops[i], 4'(i + 8), 4'(i + 1), 4'(14 - i), 15'h1234};
            fetch_to_t3(ir);
            for (int k = 0; k < (is_md(ops[i]) ? 3 : 2); k++) drive(1'b0, ir, 1'b0);
            drive(1'b0, ir, 1'b0);
            chk("loop_back_T0", PCout, 1);
        end

        // Stop during an add
        fetch_to_t3(I_ADD);
        drive(1'b0, I_ADD, 1'b1);
        chk("stop_T4_run", Run, 1);
        drive(1'b0, I_ADD, 1'b1);
        chk("stop_T5_rin", Rin, 32'h0080);
        drive(1'b0, I_ADD, 1'b1);
        chk("stop_halt_run", Run, 0);
        drive(1'b0, I_ADD, 1'b0);
        drive(1'b0, I_ADD, 1'b0);
        chk("stop_halt_stays", {Run, PCout}, 0);
        drive(1'b1, I_ADD, 1'b0);
        drive(1'b0, I_ADD, 1'b0);
        chk("after_clr_T0", PCout, 1);

        // Reset mid-instruction at T4
        fetch_to_t3(I_SUB);
        drive(1'b0, I_SUB, 1'b0);
        chk("sub_T4_zlowin", Zlowin, 1);
        drive(1'b1, I_SUB, 1'b0);
        chk("midclr_zlowin", Zlowin, 0);
        chk("midclr_regs", {Rin, Rout}, 0);
        chk("midclr_run", Run, 0);
        drive(1'b0, I_SUB, 1'b0);
        chk("midclr_T0_rin", Rin, 0);

        // Illegal opcode
        fetch_to_t3(I_ILL);
        drive(1'b0, I_ILL, 1'b0);
        chk("ill_halt_flag", Illegal, 1);
        chk("ill_halt_run", Run, 0);
        for (int n = 0; n < 10; n++) begin
            drive(1'b0, I_ILL, 1'b0);
            chk("ill_halt_hold", {Illegal, Run}, 2'b10);
        end
        drive(1'b1, I_ILL, 1'b0);
        chk("ill_clr_flag", Illegal, 0);
        drive(1'b0, I_ILL, 1'b0);

        // Halt opcode
        fetch_to_t3(I_HLT);
        chk("hlt_T3_quiet", {Rin, Rout, Yin}, 0);
        drive(1'b0, I_HLT, 1'b0);
        chk("hlt_halt", {Run, Illegal}, 0);
        drive(1'b1, I_HLT, 1'b0);
        drive(1'b0, I_HLT, 1'b0);

        // clr beats Stop at the last execute state
        fetch_to_t3(I_ADD);
        drive(1'b0, I_ADD, 1'b0);
        drive(1'b0, I_ADD, 1'b0);
        drive(1'b1, I_ADD, 1'b1);
        chk("clr_vs_stop_reset", Run, 0);
        drive(1'b0, I_ADD, 1'b0);
        chk("clr_vs_stop_T0", {Run, PCout}, 2'b11);

        drive(1'b0, I_ADD, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
